ether_in: RTL and testbench

ETHER_IN -- requirements
Module: ether_in

---
 rtl/ether_pkg.sv | 32 +++
 rtl/ether_in_if.sv | 18 +
 rtl/crc32_dibit.sv | 44 ++++
 rtl/ether_in.sv | 132 +++++++++++++
 tb/tb_ether_in.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ether_pkg.sv
// ether_pkg: shared definitions for the RMII receive and transmit paths.
// Holds the receive FSM state type, the preamble/SFD dibit codes and the
// CRC-32 constants, plus the bit-serial CRC step used by crc32_dibit.
package ether_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  // Register value left after a frame whose complemented FCS was appended.
  localparam logic [31:0] CRC_RESIDUE    = 32'hC704_DD7B;

  // One MSB-first shift of the CRC register with one wire bit.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b);
    logic fb;
    fb = crc[31] ^ b;
    crc_step = {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
  endfunction

  // Two shifts per dibit; rxd[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] dibit);
    crc_dibit = crc_step(crc_step(crc, dibit[0]), dibit[1]);
  endfunction

endpackage

// File: rtl/ether_in_if.sv
// ether_in_if: RMII receive side bundle plus the payload/result outputs.
//   crsdv, rxd             : RMII carrier-sense/data-valid and dibit
//   axiov, axiod           : payload dibit valid and data (FCS stripped)
//   frame_done, crc_ok     : end-of-frame pulse and FCS verdict
// master = stimulus/PHY side, slave = receiver side.
interface ether_in_if;
  logic       crsdv;
  logic [1:0] rxd;
  logic       axiov;
  logic [1:0] axiod;
  logic       frame_done;
  logic       crc_ok;

  modport master (output crsdv, output rxd,
                  input axiov, input axiod, input frame_done, input crc_ok);
  modport slave  (input crsdv, input rxd,
                  output axiov, output axiod, output frame_done, output crc_ok);
endinterface

// File: rtl/crc32_dibit.sv
// crc32_dibit: CRC-32 engine consuming one dibit per clock.
//   clk, rst : clock and synchronous active-high reset
//   clear    : reload CRC_INIT (wins over enable)
//   enable   : fold dibit into the register this cycle
//   dibit    : input dibit, bit 0 first
//   crc      : current register value
module crc32_dibit
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: reload, update or hold.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = crc_dibit(crc_q, dibit);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ether_in.sv
// ether_in: RMII frame receiver. Finds preamble + SFD, streams the frame
// body out with the trailing FCS stripped (via a FCS_DIBITS-deep delay line)
// and reports the FCS check when carrier drops.
//   clk, rst : clock and synchronous active-high reset
//   rx       : ether_in_if.slave (crsdv/rxd in; axiov/axiod/frame_done/crc_ok out)
module ether_in
  import ether_pkg::*;
#(
  parameter int PREAMBLE_MIN = 8,
  parameter int FCS_DIBITS   = 16
) (
  input  logic     clk,
  input  logic     rst,
  ether_in_if.slave rx
);

  localparam int PCNT_W = $clog2(PREAMBLE_MIN + 1);
  localparam int FILL_W = $clog2(FCS_DIBITS + 1);
  localparam int DCNT_W = $clog2(FCS_DIBITS + 9);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PREAMBLE_MIN);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FCS_DIBITS);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  // Minimum data dibits (FCS + 8) for a frame to be eligible for crc_ok.
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(FCS_DIBITS + 8);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);

  rx_state_e         state_q;
  logic [PCNT_W-1:0] pre_cnt_q;
  logic [FILL_W-1:0] fill_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic [1:0]        line_q [FCS_DIBITS];
  logic              axiov_q;
  logic [1:0]        axiod_q;
  logic              done_q;
  logic              ok_q;

  logic        crc_clear_s;
  logic        crc_en_s;
  logic [31:0] crc_s;

  // CRC is held at its initial value outside DATA, so every frame starts fresh.
  assign crc_clear_s = (state_q != ST_DATA);
  assign crc_en_s    = (state_q == ST_DATA) && rx.crsdv;

  crc32_dibit u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crc_clear_s),
    .enable (crc_en_s),
    .dibit  (rx.rxd),
    .crc    (crc_s)
  );

  // Receive FSM, delay line and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= '0;
      fill_q    <= '0;
      dcnt_q    <= '0;
      for (int i = 0; i < FCS_DIBITS; i++) line_q[i] <= 2'b00;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      axiov_q <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pre_cnt_q <= '0;
          fill_q    <= '0;
          dcnt_q    <= '0;
          if (rx.crsdv) begin
            if (rx.rxd == PREAMBLE_DIBIT) begin
              state_q   <= ST_PREAMBLE;
              pre_cnt_q <= PCNT_ONE;
            end else begin
              state_q <= ST_DROP;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PREAMBLE: begin
          if (!rx.crsdv) begin
            state_q <= ST_IDLE;
          end else if (rx.rxd == PREAMBLE_DIBIT) begin
            if (pre_cnt_q != PCNT_MAX) pre_cnt_q <= pre_cnt_q + PCNT_ONE;
          end else if ((rx.rxd == SFD_DIBIT) && (pre_cnt_q == PCNT_MAX)) begin
            state_q <= ST_DATA;
          end else begin
            state_q <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (rx.crsdv) begin
            for (int i = FCS_DIBITS - 1; i > 0; i--) line_q[i] <= line_q[i-1];
            line_q[0] <= rx.rxd;
            // Once full, the dibit falling off the end is payload; the
            // last FCS_DIBITS of the frame stay behind and are discarded.
            if (fill_q == FILL_MAX) begin
              axiov_q <= 1'b1;
              axiod_q <= line_q[FCS_DIBITS-1];
            end else begin
              fill_q <= fill_q + FILL_ONE;
            end
            if (dcnt_q != DCNT_MAX) dcnt_q <= dcnt_q + DCNT_ONE;
          end else begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            ok_q    <= (crc_s == CRC_RESIDUE) && (dcnt_q == DCNT_MAX);
          end
        end
        ST_DROP: begin
          if (!rx.crsdv) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx.axiov      = axiov_q;
  assign rx.axiod      = axiod_q;
  assign rx.frame_done = done_q;
  assign rx.crc_ok     = ok_q;

endmodule

// File: tb/tb_ether_in.sv
// tb_ether_in: table-driven and randomized frames checked against a
// frame-level reference model (payload = body minus trailing FCS, verdict
// from an arithmetic CRC over the body), plus reset and back-to-back cases.
module tb_ether_in;
  import ether_pkg::*;

  localparam int PRE_MIN    = 8;
  localparam int FCS_D      = 16;
  localparam int MIN_DIBITS = FCS_D + 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ether_in_if bus ();

  ether_in #(.PREAMBLE_MIN(PRE_MIN), .FCS_DIBITS(FCS_D)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] got_q[$];
  logic       ok_seen_q[$];
  int         stray_ok = 0;
  logic [1:0] exp_q[$];
  logic       exp_ok_q[$];
  logic [1:0] frm[$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.axiov === 1'b1) got_q.push_back(bus.axiod);
    if (bus.frame_done === 1'b1) ok_seen_q.push_back(bus.crc_ok);
    if ((bus.frame_done === 1'b0) && (bus.crc_ok !== 1'b0)) stray_ok++;
  end

  function automatic logic [31:0] ref_crc(input logic [1:0] d[$]);
    logic [31:0] c;
    logic        b;
    c = CRC_INIT;
    foreach (d[i]) begin
      for (int k = 0; k < 2; k++) begin
        b = d[i][k];
        if (c[31] ^ b) c = (c << 1) ^ CRC_POLY;
        else           c = c << 1;
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [1:0] d);
    @(negedge clk);
    bus.crsdv = c;
    bus.rxd   = d;
  endtask

  // Random body of nbytes, optional correct FCS, optional single bit flip.
  task automatic build_payload(input int nbytes, input bit add_fcs, input int flip);
    logic [7:0]  b;
    logic [31:0] fcs;
    logic [1:0]  t;
    frm.delete();
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) frm.push_back({b[2*k+1], b[2*k]});
    end
    if (add_fcs) begin
      fcs = ~ref_crc(frm);
      for (int k = 0; k < 16; k++) frm.push_back({fcs[30-2*k], fcs[31-2*k]});
    end
    if ((flip >= 0) && (flip < 2 * frm.size())) begin
      t = frm[flip/2];
      t[flip%2] = ~t[flip%2];
      frm[flip/2] = t;
    end
  endtask

  // Send preamble, SFD, body, then one carrier-low cycle; record model outcome.
  task automatic send(input string name, input int npre, input logic [1:0] sfd);
    bit reached;
    int n;
    int first;
    n = frm.size();
    reached = (npre >= PRE_MIN) && (sfd == SFD_DIBIT);
    for (int i = 0; i < npre; i++) drive(1'b1, PREAMBLE_DIBIT);
    drive(1'b1, sfd);
    first = -1;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if ((first < 0) && (bus.axiov === 1'b1)) first = k - 1;
      if (k <= n) begin
        bus.crsdv = 1'b1;
        bus.rxd   = frm[k-1];
      end else begin
        bus.crsdv = 1'b0;
        bus.rxd   = 2'b00;
      end
    end
    if (reached) begin
      for (int i = 0; i < n - FCS_D; i++) exp_q.push_back(frm[i]);
      exp_ok_q.push_back((ref_crc(frm) == CRC_RESIDUE) && (n >= MIN_DIBITS));
      if (n > FCS_D) check({name, " first-out edge after SFD"}, first, 17);
    end
  endtask

  task automatic compare(input string name);
    int mism;
    repeat (4) drive(1'b0, 2'b00);
    check({name, " valid count"}, got_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({name, " payload mismatches"}, mism, 0);
    check({name, " done count"}, ok_seen_q.size(), exp_ok_q.size());
    for (int i = 0; i < ok_seen_q.size() && i < exp_ok_q.size(); i++)
      check({name, " crc_ok"}, int'(ok_seen_q[i]), int'(exp_ok_q[i]));
    got_q.delete();
    ok_seen_q.delete();
    exp_q.delete();
    exp_ok_q.delete();
  endtask

  typedef struct {
    string      name;
    int         npre;
    logic [1:0] sfd;
    int         nbytes;
    bit         fcs;
    int         flip;
    int         exp_valid;
    int         exp_done;
    int         exp_ok;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{"good64",     8,  2'b11, 64, 1'b1, -1, 256, 1, 1};
    tbl[1] = '{"flip64",     8,  2'b11, 64, 1'b1, 37, 256, 1, 0};
    tbl[2] = '{"pre7",       7,  2'b11, 64, 1'b1, -1, 0,   0, 0};
    tbl[3] = '{"runt20",     8,  2'b11, 5,  1'b0, -1, 4,   1, 0};
    tbl[4] = '{"pre12",      12, 2'b11, 46, 1'b1, -1, 184, 1, 1};
    tbl[5] = '{"badsfd",     8,  2'b10, 10, 1'b1, -1, 0,   0, 0};
    tbl[6] = '{"nopre",      0,  2'b11, 10, 1'b1, -1, 0,   0, 0};
    tbl[7] = '{"min24",      8,  2'b11, 2,  1'b1, -1, 8,   1, 1};
    tbl[8] = '{"short20fcs", 8,  2'b11, 1,  1'b1, -1, 4,   1, 0};

    rst = 1'b1;
    bus.crsdv = 1'b0;
    bus.rxd   = 2'b00;
    repeat (3) @(negedge clk);
    check("reset axiov", int'(bus.axiov), 0);
    check("reset axiod", int'(bus.axiod), 0);
    check("reset frame_done", int'(bus.frame_done), 0);
    check("reset crc_ok", int'(bus.crc_ok), 0);
    rst = 1'b0;
    repeat (2) drive(1'b0, 2'b00);

    // Table-driven frames.
    for (int v = 0; v < 9; v++) begin
      build_payload(tbl[v].nbytes, tbl[v].fcs, tbl[v].flip);
      send(tbl[v].name, tbl[v].npre, tbl[v].sfd);
      repeat (4) drive(1'b0, 2'b00);
      check({tbl[v].name, " table valid"}, got_q.size(), tbl[v].exp_valid);
      check({tbl[v].name, " table done"}, ok_seen_q.size(), tbl[v].exp_done);
      if (ok_seen_q.size() == 1)
        check({tbl[v].name, " table crc_ok"}, int'(ok_seen_q[0]), tbl[v].exp_ok);
      compare(tbl[v].name);
    end

    // SFD followed immediately by carrier loss: DATA reached with no body.
    frm.delete();
    send("empty", 8, 2'b11);
    compare("empty");

    // Reset during body dibit 100 aborts the frame.
    build_payload(64, 1'b1, -1);
    for (int i = 0; i < 8; i++) drive(1'b1, PREAMBLE_DIBIT);
    drive(1'b1, SFD_DIBIT);
    for (int i = 0; i < 100; i++) drive(1'b1, frm[i]);
    @(negedge clk);
    rst = 1'b1;
    bus.rxd = frm[100];
    @(negedge clk);
    check("rst axiov next cycle", int'(bus.axiov), 0);
    rst = 1'b0;
    bus.crsdv = 1'b1;
    bus.rxd = 2'b00;
    repeat (5) drive(1'b1, 2'b00);
    for (int i = 0; i < 100 - FCS_D; i++) exp_q.push_back(frm[i]);
    compare("rst-abort");
    build_payload(30, 1'b1, -1);
    send("after-rst", 8, 2'b11);
    compare("after-rst");

    // Back-to-back frames, one carrier-low cycle between them.
    build_payload(20, 1'b1, -1);
    send("b2b-a", 8, 2'b11);
    build_payload(33, 1'b1, -1);
    send("b2b-b", 9, 2'b11);
    compare("b2b");

    // Randomized frames against the reference model.
    for (int r = 0; r < 14; r++) begin
      int npre, sel, nb, flip;
      logic [1:0] sfd;
      bit fcs;
      npre = $urandom_range(0, 12);
      sel  = $urandom_range(0, 4);
      sfd  = (sel < 3) ? 2'b11 : ((sel == 3) ? 2'b10 : 2'b00);
      nb   = $urandom_range(0, 30);
      fcs  = 1'($urandom_range(0, 1));
      flip = (($urandom_range(0, 3) == 0) && (nb > 0)) ? $urandom_range(0, nb * 8 - 1) : -1;
      build_payload(nb, fcs, flip);
      send("rand", npre, sfd);
      compare("rand");
    end

    check("crc_ok without frame_done", stray_ok, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
